// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU control blocks: the flush/redirect FSM state
// encoding and the default fetch-outstanding depth.
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   // Default number of fetch requests that may be in flight at once.
   localparam int FRC_MAX_OUTSTANDING = 4;

   // Flush/redirect sequencer states (2-bit encoding).
   typedef enum logic [1:0] {
      FRC_IDLE     = 2'd0,
      FRC_DRAIN    = 2'd1,
      FRC_REDIRECT = 2'd2
   } frc_state_e;

endpackage : cpu_ctrl_pkg

// File: rtl/flush_redirect_ctrl_if.sv
// ----------------------------------------------------------------------------
// flush_redirect_ctrl_if
// Bundles the exception/ERET inputs, the IF fetch-port observation signals and
// the redirect handshake of the flush/redirect sequencer.
//   slave  : the sequencer's view (flush_redirect_ctrl)
//   master : the environment's view (CP0, commit logic, IF stage)
// ----------------------------------------------------------------------------
interface flush_redirect_ctrl_if #(
   parameter int CNT_W = $clog2(cpu_ctrl_pkg::FRC_MAX_OUTSTANDING + 1)
) ();

   logic             exception;
   logic [31:0]      exception_handler_entry;
   logic             eret_commit;
   logic [31:0]      epc_in;
   logic             if_req_fire;
   logic             if_resp_fire;
   logic             if_req_allow;
   logic             resp_discard;
   logic             flush;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             redirect_ready;
   logic             busy;
   logic [CNT_W-1:0] outstanding;

   modport slave (
      input  exception, exception_handler_entry, eret_commit, epc_in,
             if_req_fire, if_resp_fire, redirect_ready,
      output if_req_allow, resp_discard, flush, redirect_valid, redirect_pc,
             busy, outstanding
   );

   modport master (
      output exception, exception_handler_entry, eret_commit, epc_in,
             if_req_fire, if_resp_fire, redirect_ready,
      input  if_req_allow, resp_discard, flush, redirect_valid, redirect_pc,
             busy, outstanding
   );

endinterface : flush_redirect_ctrl_if

// File: rtl/fetch_outstanding_cnt.sv
// ----------------------------------------------------------------------------
// fetch_outstanding_cnt
// Saturating up/down counter of in-flight fetch requests.
//   inc        : request accepted this cycle
//   dec        : response returned this cycle
//   count      : registered count
//   count_next : value the count takes at the next edge
//   full/empty : count == MAX / count == 0
// Simultaneous inc and dec cancel; dec at empty and inc at full are ignored.
// ----------------------------------------------------------------------------
module fetch_outstanding_cnt #(
   parameter int MAX   = cpu_ctrl_pkg::FRC_MAX_OUTSTANDING,
   parameter int CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next,
   output logic             full,
   output logic             empty
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   logic [CNT_W-1:0] count_q, count_d;

   assign full  = (count_q == MAX_C);
   assign empty = (count_q == '0);

   always_comb begin
      // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      if (inc && !dec && !full) begin
         count_d = count_q + CNT_W'(1);
      end else if (dec && !inc && !empty) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: state flops use non-blocking assignments and clear on the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count      = count_q;
   assign count_next = count_d;

endmodule : fetch_outstanding_cnt

// File: rtl/flush_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// flush_redirect_ctrl
// Pipeline recovery sequencer. On an exception (or a committing ERET) it
// latches the target, pulses flush for one cycle, blocks new fetches, drains
// and discards in-flight fetch responses, then offers one redirect to IF with
// a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : flush_redirect_ctrl_if.slave (see interface for signals)
// ----------------------------------------------------------------------------
module flush_redirect_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int MAX_OUTSTANDING = FRC_MAX_OUTSTANDING
) (
   input  logic                  clk,
   input  logic                  rst_n,
   flush_redirect_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   frc_state_e       state_q, state_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;
   logic             flush_q, flush_d;
   logic             redirect_valid_q, redirect_valid_d;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             cnt_full;
   logic             cnt_empty;

   fetch_outstanding_cnt #(
      .MAX   (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (bus.if_req_fire),
      .dec        (bus.if_resp_fire),
      .count      (cnt),
      .count_next (cnt_next),
      .full       (cnt_full),
      .empty      (cnt_empty)
   );

   always_comb begin
      state_d          = state_q;
      redirect_pc_d    = redirect_pc_q;
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      unique case (state_q)
         FRC_IDLE: begin
            // Exception wins over a simultaneous ERET.
            if (bus.exception) begin
               state_d       = FRC_DRAIN;
               redirect_pc_d = bus.exception_handler_entry;
               flush_d       = 1'b1;
            end else if (bus.eret_commit) begin
               state_d       = FRC_DRAIN;
               redirect_pc_d = bus.epc_in;
               flush_d       = 1'b1;
            end
         end
         FRC_DRAIN: begin
            // Look at count_next so a response in this cycle ends the drain now.
            if (cnt_next == '0) begin
               state_d          = FRC_REDIRECT;
               redirect_valid_d = 1'b1;
            end
         end
         FRC_REDIRECT: begin
            if (bus.redirect_ready) begin
               state_d = FRC_IDLE;
            end else begin
               redirect_valid_d = 1'b1;
            end
         end
         default: state_d = FRC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= FRC_IDLE;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
      end
   end

   // No fetch can be in flight once the drain has completed.
   a_redirect_drained : assert property (
      @(posedge clk) disable iff (!rst_n) (state_q == FRC_REDIRECT) |-> cnt_empty
   );

   assign bus.if_req_allow   = (state_q == FRC_IDLE) && !cnt_full &&
                               !bus.exception && !bus.eret_commit;
   assign bus.resp_discard   = (state_q != FRC_IDLE) && bus.if_resp_fire;
   assign bus.flush          = flush_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.busy           = (state_q != FRC_IDLE);
   assign bus.outstanding    = cnt;

endmodule : flush_redirect_ctrl

// File: tb/tb_flush_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_flush_redirect_ctrl
// Directed, table-driven bench for flush_redirect_ctrl. Each table row is one
// clock cycle: inputs applied just after the rising edge, outputs compared at
// the falling edge. A hand-written sequence covers async reset during DRAIN.
// ----------------------------------------------------------------------------
module tb_flush_redirect_ctrl;

   localparam logic [31:0] H0  = 32'hbfc0_0380;
   localparam logic [31:0] H1  = 32'h8000_0180;
   localparam logic [31:0] EPC = 32'h8000_1234;

   typedef struct {
      logic        exc;
      logic [31:0] entry;
      logic        eret;
      logic [31:0] epc;
      logic        req;
      logic        resp;
      logic        rdy;
      logic        allow;
      logic        disc;
      logic        flush;
      logic        rv;
      logic [31:0] pc;
      logic        busy;
      logic [2:0]  outst;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[$];

   flush_redirect_ctrl_if #(.CNT_W(3)) bus ();

   flush_redirect_ctrl #(.MAX_OUTSTANDING(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic exc, input logic [31:0] entry, input logic eret,
                      input logic [31:0] epc, input logic req, input logic resp,
                      input logic rdy, input logic allow, input logic disc,
                      input logic flush, input logic rv, input logic [31:0] pc,
                      input logic busy, input logic [2:0] outst);
      vec_t v;
      v.exc = exc;     v.entry = entry; v.eret = eret;   v.epc = epc;
      v.req = req;     v.resp = resp;   v.rdy = rdy;
      v.allow = allow; v.disc = disc;   v.flush = flush; v.rv = rv;
      v.pc = pc;       v.busy = busy;   v.outst = outst;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      bus.exception               = v.exc;
      bus.exception_handler_entry = v.entry;
      bus.eret_commit             = v.eret;
      bus.epc_in                  = v.epc;
      bus.if_req_fire             = v.req;
      bus.if_resp_fire            = v.resp;
      bus.redirect_ready          = v.rdy;
   endtask

   task automatic drive_idle();
      vec_t v;
      v = '{default: '0};
      drive(v);
   endtask

   initial begin
      //  exc entry eret epc   req rsp rdy | allow disc flush rv  pc   busy out
      // Exception with nothing outstanding; ready on first REDIRECT cycle.
      add(0, 0,   0, 0,      0, 0, 0,   1, 0, 0, 0, 0,   0, 0); // 0 reset state
      add(1, H0,  0, 0,      0, 0, 0,   0, 0, 0, 0, 0,   0, 0); // 1 T
      add(0, 0,   0, 0,      0, 0, 0,   0, 0, 1, 0, H0,  1, 0); // 2 DRAIN, flush
      add(0, 0,   0, 0,      0, 0, 1,   0, 0, 0, 1, H0,  1, 0); // 3 REDIRECT
      add(0, 0,   0, 0,      0, 0, 0,   1, 0, 0, 0, H0,  0, 0); // 4 IDLE
      // Three outstanding, then exception; responses at T+3..T+5.
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H0,  0, 0); // 5
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H0,  0, 1); // 6
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H0,  0, 2); // 7
      add(1, H1,  0, 0,      0, 0, 0,   0, 0, 0, 0, H0,  0, 3); // 8 T
      add(0, 0,   0, 0,      0, 0, 0,   0, 0, 1, 0, H1,  1, 3); // 9
      add(0, 0,   0, 0,      0, 0, 0,   0, 0, 0, 0, H1,  1, 3); // 10
      add(0, 0,   0, 0,      0, 1, 0,   0, 1, 0, 0, H1,  1, 3); // 11 T+3
      add(0, 0,   0, 0,      0, 1, 0,   0, 1, 0, 0, H1,  1, 2); // 12 T+4
      add(0, 0,   0, 0,      0, 1, 0,   0, 1, 0, 0, H1,  1, 1); // 13 T+5
      add(0, 0,   0, 0,      0, 0, 0,   0, 0, 0, 1, H1,  1, 0); // 14 T+6 REDIRECT
      add(0, 0,   0, 0,      0, 0, 1,   0, 0, 0, 1, H1,  1, 0); // 15
      add(0, 0,   0, 0,      0, 0, 0,   1, 0, 0, 0, H1,  0, 0); // 16
      // ERET with two outstanding; ready held low four cycles.
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H1,  0, 0); // 17
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H1,  0, 1); // 18
      add(0, 0,   1, EPC,    0, 0, 0,   0, 0, 0, 0, H1,  0, 2); // 19 T
      add(0, 0,   0, 0,      0, 1, 0,   0, 1, 1, 0, EPC, 1, 2); // 20
      add(0, 0,   0, 0,      0, 1, 0,   0, 1, 0, 0, EPC, 1, 1); // 21
      add(0, 0,   0, 0,      0, 0, 0,   0, 0, 0, 1, EPC, 1, 0); // 22
      add(0, 0,   0, 0,      0, 0, 0,   0, 0, 0, 1, EPC, 1, 0); // 23
      add(0, 0,   0, 0,      0, 0, 0,   0, 0, 0, 1, EPC, 1, 0); // 24
      add(0, 0,   0, 0,      0, 0, 0,   0, 0, 0, 1, EPC, 1, 0); // 25
      add(0, 0,   0, 0,      0, 0, 1,   0, 0, 0, 1, EPC, 1, 0); // 26 ready
      add(0, 0,   0, 0,      0, 0, 0,   1, 0, 0, 0, EPC, 0, 0); // 27 IDLE
      // Exception + ERET together; later events while busy are ignored.
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, EPC, 0, 0); // 28
      add(1, H0,  1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, EPC, 0, 1); // 29 T
      add(1, 0,   0, 0,      0, 0, 0,   0, 0, 1, 0, H0,  1, 1); // 30 exc in DRAIN
      add(0, 0,   0, 0,      0, 1, 0,   0, 1, 0, 0, H0,  1, 1); // 31
      add(0, 0,   1, 0,      0, 0, 1,   0, 0, 0, 1, H0,  1, 0); // 32 eret in REDIRECT
      add(0, 0,   0, 0,      0, 0, 0,   1, 0, 0, 0, H0,  0, 0); // 33
      // Counter limits.
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H0,  0, 0); // 34
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H0,  0, 1); // 35
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H0,  0, 2); // 36
      add(0, 0,   0, 0,      1, 0, 0,   1, 0, 0, 0, H0,  0, 3); // 37
      add(0, 0,   0, 0,      0, 1, 0,   0, 0, 0, 0, H0,  0, 4); // 38 full
      add(0, 0,   0, 0,      0, 1, 0,   1, 0, 0, 0, H0,  0, 3); // 39
      add(0, 0,   0, 0,      1, 1, 0,   1, 0, 0, 0, H0,  0, 2); // 40 req+resp
      add(0, 0,   0, 0,      0, 1, 0,   1, 0, 0, 0, H0,  0, 2); // 41
      add(0, 0,   0, 0,      0, 1, 0,   1, 0, 0, 0, H0,  0, 1); // 42
      add(0, 0,   0, 0,      0, 1, 0,   1, 0, 0, 0, H0,  0, 0); // 43 resp at 0
      add(0, 0,   0, 0,      0, 0, 0,   1, 0, 0, 0, H0,  0, 0); // 44

      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check($sformatf("v%0d allow", i), 32'(bus.if_req_allow),   32'(vecs[i].allow));
         check($sformatf("v%0d disc", i),  32'(bus.resp_discard),   32'(vecs[i].disc));
         check($sformatf("v%0d flush", i), 32'(bus.flush),          32'(vecs[i].flush));
         check($sformatf("v%0d rv", i),    32'(bus.redirect_valid), 32'(vecs[i].rv));
         check($sformatf("v%0d pc", i),    bus.redirect_pc,         vecs[i].pc);
         check($sformatf("v%0d busy", i),  32'(bus.busy),           32'(vecs[i].busy));
         check($sformatf("v%0d outst", i), 32'(bus.outstanding),    32'(vecs[i].outst));
         @(posedge clk);
         #1;
      end

      // Async reset while draining with two outstanding.
      drive_idle();
      bus.if_req_fire = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.if_req_fire             = 1'b0;
      bus.exception               = 1'b1;
      bus.exception_handler_entry = H1;
      @(posedge clk); #1;
      bus.exception = 1'b0;
      #1;
      check("pre_rst busy",  32'(bus.busy),        32'd1);
      check("pre_rst outst", 32'(bus.outstanding), 32'd2);
      check("pre_rst flush", 32'(bus.flush),       32'd1);
      rst_n = 1'b0;
      #1;
      check("rst busy",  32'(bus.busy),           32'd0);
      check("rst outst", 32'(bus.outstanding),    32'd0);
      check("rst flush", 32'(bus.flush),          32'd0);
      check("rst rv",    32'(bus.redirect_valid), 32'd0);
      check("rst pc",    bus.redirect_pc,         32'd0);
      check("rst allow", 32'(bus.if_req_allow),   32'd1);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("post_rst%0d rv", k),   32'(bus.redirect_valid), 32'd0);
         check($sformatf("post_rst%0d busy", k), 32'(bus.busy),           32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_flush_redirect_ctrl

// File: doc/flush_redirect_ctrl.md
Name: flush_redirect_ctrl

Overview:
- Sequences pipeline recovery after the CP0 exception unit signals an exception or after an ERET commits.
- Pulses a global flush and blocks new instruction-fetch requests.
- Drains and discards in-flight fetch responses, then presents one redirect (handler entry or EPC) to the IF stage with a valid/ready handshake.
- Sits between the exception/CP0 unit, the MA/WB commit logic and the IF fetch port.

Parameters:
- MAX_OUTSTANDING, 4, maximum number of fetch requests in flight at once.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- exception  in  1  exception taken this cycle; from the exception unit
- exception_handler_entry  in  32  handler target, valid with exception
- eret_commit  in  1  ERET leaving MA and committing this cycle
- epc_in  in  32  current EPC, valid with eret_commit
- if_req_fire  in  1  IF fetch request accepted by memory this cycle
- if_resp_fire  in  1  fetch response returned this cycle
- if_req_allow  out  1  IF may issue a request this cycle
- resp_discard  out  1  current response must be dropped by IF
- flush  out  1  one-cycle flush to all pipeline stages
- redirect_valid  out  1  redirect target available
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  IF accepts the redirect
- busy  out  1  high when not IDLE
- outstanding  out  CNT_W  current in-flight fetch count

Behaviour:
- States: IDLE, DRAIN, REDIRECT. Reset puts the block in IDLE.
- Reset values: flush=0, redirect_valid=0, redirect_pc=0, outstanding=0, busy=0.
- Reset asserted mid-operation aborts immediately: state goes to IDLE, counter clears, and no redirect is issued.
- Outstanding counter:
  - count_next = count + if_req_fire − if_resp_fire.
  - Request and response in the same cycle leave the count unchanged.
  - if_resp_fire with count==0 is ignored; the count stays 0.
  - if_req_fire with count==MAX_OUTSTANDING never occurs, because if_req_allow is low.
- if_req_allow = (state==IDLE) && (count<MAX_OUTSTANDING) && !exception && !eret_commit. It is combinational.
- IDLE, at cycle T with exception=1:
  - Latch exception_handler_entry into redirect_pc.
  - Go to DRAIN; flush=1 during cycle T+1 only.
  - exception has priority over a simultaneous eret_commit.
- IDLE, at cycle T with eret_commit=1 and exception=0: same as above, latching epc_in instead.
- DRAIN:
  - resp_discard = if_resp_fire.
  - Leave for REDIRECT when count_next==0, evaluated every cycle including the first DRAIN cycle.
  - If the count is already 0 on entry, the block spends exactly 1 cycle in DRAIN.
- REDIRECT:
  - redirect_valid=1; redirect_pc is held stable.
  - On redirect_ready=1, go to IDLE at the next edge; redirect_valid drops that cycle.
  - Responses in REDIRECT are also discarded; none are legal.
- exception or eret_commit while not IDLE is ignored; the pipeline is already flushing and the latched target is kept.
- busy = (state!=IDLE).
- End-to-end latency, exception to redirect_valid, is 2 + (cycles to drain).

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state encoding constants FRC_IDLE, FRC_DRAIN, FRC_REDIRECT (2-bit);
  - the default MAX_OUTSTANDING value.
- One sub-module, fetch_outstanding_cnt: a saturating up/down counter with inputs inc, dec, outputs count and count_next, and full/empty flags.

Test Plan:
- Exception with 0 outstanding and entry=0xbfc00380 -> flush at T+1; DRAIN for 1 cycle; redirect_valid at T+2 with pc=0xbfc00380; redirect_ready asserted at T+2 -> IDLE at T+3.
- 3 requests outstanding, then exception; responses return at T+3, T+4, T+5 -> resp_discard high on each; REDIRECT entered at T+6; if_req_allow low from T through the redirect.
- eret_commit with epc_in=0x80001234 while 2 outstanding, redirect_ready held low for 4 cycles -> redirect_valid and pc=0x80001234 held stable for all 4 cycles; IDLE the cycle after ready.
- exception and eret_commit together with entry=0xbfc00380 and epc_in=0x1000 -> redirect_pc=0xbfc00380; a second exception during DRAIN carrying a new entry 0x0 does not change the target.
- Issue 4 requests with no responses -> outstanding=4 and if_req_allow=0; a simultaneous req_fire and resp_fire at count=2 leaves the count at 2; a resp_fire at count 0 leaves the count at 0.
- Drop rst_n asynchronously while in DRAIN with 2 outstanding -> state IDLE and outstanding=0 immediately, with no wait for a clock edge; flush and redirect_valid are 0.
